// File: rtl/timer_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : timer_reg_ctrl
// Description : Software register port and architectural state for the timer
//               core (mtime, mtimecmp, core configuration, interrupt bits).
// Revision    : 1.0 - initial release
// ============================================================================
module timer_reg_ctrl #(
   parameter int unsigned AW            = 6,
   parameter logic [11:0] RST_PRESCALER = 12'd0,
   parameter logic [7:0]  RST_STEP      = 8'd1
) (
   input  logic          clk_i,
   input  logic          rst_ni,

   input  logic          reg_req_i,
   input  logic          reg_we_i,
   input  logic [AW-1:0] reg_addr_i,
   input  logic [31:0]   reg_wdata_i,
   output logic          reg_rvalid_o,
   output logic [31:0]   reg_rdata_o,
   output logic          reg_err_o,

   output logic          active_o,
   output logic [11:0]   prescaler_o,
   output logic [7:0]    step_o,
   output logic [63:0]   mtime_o,
   output logic [63:0]   mtimecmp_o,
   input  logic          tick_i,
   input  logic [63:0]   mtime_d_i,
   input  logic          intr_i,
   output logic          irq_o
);

   localparam logic [AW-1:0] c_ADDR_CTRL        = AW'(8'h00);
   localparam logic [AW-1:0] c_ADDR_CFG         = AW'(8'h04);
   localparam logic [AW-1:0] c_ADDR_MTIME_LO    = AW'(8'h08);
   localparam logic [AW-1:0] c_ADDR_MTIME_HI    = AW'(8'h0C);
   localparam logic [AW-1:0] c_ADDR_MTIMECMP_LO = AW'(8'h10);
   localparam logic [AW-1:0] c_ADDR_MTIMECMP_HI = AW'(8'h14);
   localparam logic [AW-1:0] c_ADDR_INTR_EN     = AW'(8'h18);
   localparam logic [AW-1:0] c_ADDR_INTR_STATE  = AW'(8'h1C);
   localparam logic [AW-1:0] c_ADDR_INTR_TEST   = AW'(8'h20);

   logic [31:0]   r_hi_shadow;
   logic          r_intr_enable;
   logic          r_intr_state;

   logic [AW-1:0] w_addr;
   logic          w_wr;
   logic          w_rd;
   logic          w_sel_ctrl;
   logic          w_sel_cfg;
   logic          w_sel_mtime_lo;
   logic          w_sel_mtime_hi;
   logic          w_sel_cmp_lo;
   logic          w_sel_cmp_hi;
   logic          w_sel_intr_en;
   logic          w_sel_intr_state;
   logic          w_sel_intr_test;
   logic          w_hit;
   logic [31:0]   w_rdata;
   logic          w_intr_enable_d;
   logic          w_intr_state_d;

   // Byte offsets are word aligned; the low two address bits never select.
   assign w_addr = reg_addr_i & ~AW'(3);
   assign w_wr   = reg_req_i &  reg_we_i;
   assign w_rd   = reg_req_i & ~reg_we_i;

   assign w_sel_ctrl       = (w_addr == c_ADDR_CTRL);
   assign w_sel_cfg        = (w_addr == c_ADDR_CFG);
   assign w_sel_mtime_lo   = (w_addr == c_ADDR_MTIME_LO);
   assign w_sel_mtime_hi   = (w_addr == c_ADDR_MTIME_HI);
   assign w_sel_cmp_lo     = (w_addr == c_ADDR_MTIMECMP_LO);
   assign w_sel_cmp_hi     = (w_addr == c_ADDR_MTIMECMP_HI);
   assign w_sel_intr_en    = (w_addr == c_ADDR_INTR_EN);
   assign w_sel_intr_state = (w_addr == c_ADDR_INTR_STATE);
   assign w_sel_intr_test  = (w_addr == c_ADDR_INTR_TEST);

   assign w_hit = w_sel_ctrl | w_sel_cfg | w_sel_mtime_lo | w_sel_mtime_hi |
                  w_sel_cmp_lo | w_sel_cmp_hi | w_sel_intr_en |
                  w_sel_intr_state | w_sel_intr_test;

   always_comb begin
      w_rdata = '0;
      if (w_sel_ctrl)       w_rdata = {31'd0, active_o};
      if (w_sel_cfg)        w_rdata = {8'd0, step_o, 4'd0, prescaler_o};
      if (w_sel_mtime_lo)   w_rdata = mtime_o[31:0];
      if (w_sel_mtime_hi)   w_rdata = r_hi_shadow;
      if (w_sel_cmp_lo)     w_rdata = mtimecmp_o[31:0];
      if (w_sel_cmp_hi)     w_rdata = mtimecmp_o[63:32];
      if (w_sel_intr_en)    w_rdata = {31'd0, r_intr_enable};
      if (w_sel_intr_state) w_rdata = {31'd0, r_intr_state};
   end

   // Set sources (core event, test write) win over a same-cycle W1C.
   assign w_intr_state_d = (r_intr_state & ~(w_wr & w_sel_intr_state & reg_wdata_i[0]))
                         | intr_i
                         | (w_wr & w_sel_intr_test & reg_wdata_i[0]);
   assign w_intr_enable_d = (w_wr & w_sel_intr_en) ? reg_wdata_i[0] : r_intr_enable;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         reg_rvalid_o <= 1'b0;
         reg_rdata_o  <= '0;
         reg_err_o    <= 1'b0;
      end else begin
         reg_rvalid_o <= reg_req_i;
         reg_rdata_o  <= w_rd ? w_rdata : '0;
         reg_err_o    <= reg_req_i & ~w_hit;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_o    <= 1'b0;
         prescaler_o <= RST_PRESCALER;
         step_o      <= RST_STEP;
         mtimecmp_o  <= '1;
      end else begin
         if (w_wr && w_sel_ctrl) active_o <= reg_wdata_i[0];
         if (w_wr && w_sel_cfg) begin
            prescaler_o <= reg_wdata_i[11:0];
            step_o      <= reg_wdata_i[23:16];
         end
         if (w_wr && w_sel_cmp_lo) mtimecmp_o[31:0]  <= reg_wdata_i;
         if (w_wr && w_sel_cmp_hi) mtimecmp_o[63:32] <= reg_wdata_i;
      end
   end

   // A software write to either mtime half drops that cycle's tick.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mtime_o     <= '0;
         r_hi_shadow <= '0;
      end else begin
         if (w_wr && w_sel_mtime_lo) begin
            mtime_o[31:0] <= reg_wdata_i;
         end else if (w_wr && w_sel_mtime_hi) begin
            mtime_o[63:32] <= reg_wdata_i;
         end else if (tick_i) begin
            mtime_o <= mtime_d_i;
         end
         if (w_rd && w_sel_mtime_lo) r_hi_shadow <= mtime_o[63:32];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_intr_enable <= 1'b0;
         r_intr_state  <= 1'b0;
         irq_o         <= 1'b0;
      end else begin
         r_intr_enable <= w_intr_enable_d;
         r_intr_state  <= w_intr_state_d;
         irq_o         <= w_intr_state_d & w_intr_enable_d;
      end
   end

endmodule
`default_nettype wire
